// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus types for the memory-issue path: request/response structs and access sizes.
package dbus_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  typedef logic [3:0]  strobe_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  // A zero strobe marks a load; stores always carry at least one byte lane.
  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_arbiter_load_align.sv
// Picks the addressed byte/half/word out of a bus word and zero- or sign-extends it.
module load_align
  import dbus_arbiter_pkg::*;
(
  input  word_t      data,
  input  logic [1:0] addr,
  input  msize_t     size,
  input  logic       lsign,
  output word_t      result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = data[{addr, 3'b000} +: 8];
    half_v = addr[1] ? data[31:16] : data[15:0];
    unique case (size)
      MSIZE1:  result = {{24{lsign & byte_v[7]}}, byte_v};
      MSIZE2:  result = {{16{lsign & half_v[15]}}, half_v};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Serialises the two issue slots onto the single data bus in program order and
// stalls the issue group until every access has completed or been drained.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  req0,
  input  dbus_req_t  req1,
  input  logic       lsign0,
  input  logic       lsign1,
  input  logic       cp0_flush,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output logic       stall,
  output word_t      rdata0,
  output word_t      rdata1
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DRAIN, S_DONE
  } state_e;

  state_e    state_q, state_d;
  dbus_req_t req0_q, req0_d, req1_q, req1_d;
  logic      lsign0_q, lsign0_d, lsign1_q, lsign1_d;
  word_t     rd0_q, rd0_d, rd1_q, rd1_d;
  word_t     al0, al1;
  logic      is_req, slot1, xfer_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      req0_q   <= '0;
      req1_q   <= '0;
      lsign0_q <= 1'b0;
      lsign1_q <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      req0_q   <= req0_d;
      req1_q   <= req1_d;
      lsign0_q <= lsign0_d;
      lsign1_q <= lsign1_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req0_d    = req0_q;
    req1_d    = req1_q;
    lsign0_d  = lsign0_q;
    lsign1_d  = lsign1_q;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    dreq      = '0;
    stall     = 1'b1;
    is_req    = (state_q == S_REQ0) || (state_q == S_REQ1);
    slot1     = (state_q == S_REQ1) || (state_q == S_WAIT1);
    xfer_done = dresp.data_ok & (dresp.addr_ok | ~is_req);
    unique case (state_q)
      S_IDLE: begin
        stall = req0.valid | req1.valid;
        if (!cp0_flush && (req0.valid || req1.valid)) begin
          req0_d   = req0;
          req1_d   = req1;
          lsign0_d = lsign0;
          lsign1_d = lsign1;
          rd0_d    = '0;
          rd1_d    = '0;
          state_d  = req0.valid ? S_REQ0 : S_REQ1;
        end
      end
      S_REQ0, S_REQ1, S_WAIT0, S_WAIT1: begin
        if (is_req) begin
          dreq       = slot1 ? req1_q : req0_q;
          // A flush withdraws the request unless the bus already took it this cycle.
          dreq.valid = dresp.addr_ok | ~cp0_flush;
        end
        if (cp0_flush) begin
          if (is_req && !dresp.addr_ok) state_d = S_IDLE;
          else                          state_d = dresp.data_ok ? S_IDLE : S_DRAIN;
        end else if (xfer_done) begin
          if (slot1) begin
            rd1_d   = dresp.data;
            state_d = S_DONE;
          end else begin
            rd0_d   = dresp.data;
            state_d = req1_q.valid ? S_REQ1 : S_DONE;
          end
        end else if (is_req && dresp.addr_ok) begin
          state_d = slot1 ? S_WAIT1 : S_WAIT0;
        end
      end
      S_DRAIN: begin
        if (dresp.data_ok) state_d = S_IDLE;
      end
      S_DONE: begin
        stall   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  load_align u_align0 (
    .data(rd0_q), .addr(req0_q.addr[1:0]), .size(req0_q.size), .lsign(lsign0_q), .result(al0)
  );
  load_align u_align1 (
    .data(rd1_q), .addr(req1_q.addr[1:0]), .size(req1_q.size), .lsign(lsign1_q), .result(al1)
  );

  // Results are only presented in DONE, and never for stores or empty slots.
  assign rdata0 = (state_q == S_DONE && req0_q.valid && req0_q.strobe == '0) ? al0 : '0;
  assign rdata1 = (state_q == S_DONE && req1_q.valid && req1_q.strobe == '0) ? al1 : '0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed corner sequences, an alignment vector table, and
// randomized issue groups against a queue-based bus/result model.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  dbus_req_t  req0, req1, dreq;
  dbus_resp_t dresp;
  logic       lsign0, lsign1, cp0_flush, stall;
  word_t      rdata0, rdata1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbus_arbiter dut (
    .clk(clk), .resetn(resetn), .req0(req0), .req1(req1), .lsign0(lsign0), .lsign1(lsign1),
    .cp0_flush(cp0_flush), .dreq(dreq), .dresp(dresp), .stall(stall), .rdata0(rdata0), .rdata1(rdata1)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkreq(input string name, input dbus_req_t act, input dbus_req_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic dbus_req_t mk(logic v, addr_t a, msize_t s, strobe_t st, word_t d);
    dbus_req_t r;
    r.valid = v; r.addr = a; r.size = s; r.strobe = st; r.data = d;
    return r;
  endfunction

  // Reference extraction: shift the addressed lane down, mask to width, then extend.
  function automatic word_t ref_align(word_t d, logic [1:0] a, msize_t s, logic sg);
    word_t v;
    int unsigned sh;
    sh = 8 * a;
    v = d >> sh;
    case (s)
      MSIZE1: begin v = v & 32'hFF;   if (sg && v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      MSIZE2: begin v = v & 32'hFFFF; if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000; end
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic dbus_req_t rnd_req(logic v);
    dbus_req_t r;
    msize_t    sz;
    word_t     a;
    strobe_t   st;
    sz = msize_t'($urandom_range(0, 2));
    a  = $urandom;
    case (sz)
      MSIZE2:  a[0] = 1'b0;
      MSIZE4:  a[1:0] = 2'b00;
      default: ;
    endcase
    st = 4'h0;
    if ($urandom_range(0, 1) == 1) begin
      case (sz)
        MSIZE1:  st = 4'b0001 << a[1:0];
        MSIZE2:  st = 4'b0011 << a[1:0];
        default: st = 4'hF;
      endcase
    end
    r = mk(v, a, sz, st, $urandom);
    return r;
  endfunction

  typedef struct {
    msize_t     sz;
    logic [1:0] a;
    logic       sg;
    strobe_t    st;
    word_t      bus;
    word_t      exp;
  } vec_t;

  vec_t       vecs [9];
  dbus_req_t  r [2];
  dbus_req_t  r0, prev, zero_req;
  logic       sg [2];
  word_t      exp_rd [2];
  word_t      bd;
  int         order [$];
  int         idx, cnt, slot, nd;
  logic       pend, hold, done;

  initial begin
    zero_req = '0;
    req0 = '0; req1 = '0; lsign0 = 1'b0; lsign1 = 1'b0; cp0_flush = 1'b0; dresp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_stall", stall, 1'b0);
    chkreq("reset_dreq", dreq, zero_req);
    chk32("reset_rdata0", rdata0, 32'h0);
    chk32("reset_rdata1", rdata1, 32'h0);
    resetn = 1'b1;

    // Single LW: addr_ok at cycle 1, data_ok at cycle 3.
    tick(); req0 = mk(1'b1, 32'h8000_0010, MSIZE4, 4'h0, 32'h0); #1;
    chk1("lw_c0_stall", stall, 1'b1);
    chk1("lw_c0_valid", dreq.valid, 1'b0);
    tick(); req0 = '0; #1;
    chk1("lw_c1_valid", dreq.valid, 1'b1);
    chk32("lw_c1_addr", dreq.addr, 32'h8000_0010);
    dresp.addr_ok = 1'b1;
    tick(); dresp = '0; #1;
    chk1("lw_c2_valid", dreq.valid, 1'b0);
    chk1("lw_c2_stall", stall, 1'b1);
    tick(); #1;
    chk1("lw_c3_stall", stall, 1'b1);
    dresp.data_ok = 1'b1; dresp.data = 32'hDEAD_BEEF;
    tick(); dresp = '0; #1;
    chk1("lw_done_stall", stall, 1'b0);
    chk32("lw_done_rdata0", rdata0, 32'hDEAD_BEEF);
    chk32("lw_done_rdata1", rdata1, 32'h0);
    tick(); #1;
    chk1("lw_idle_stall", stall, 1'b0);

    // Dual issue: SB in slot 0, signed LB in slot 1, both acked in one cycle.
    tick();
    req0 = mk(1'b1, 32'h1000_0003, MSIZE1, 4'b1000, 32'h5A00_0000);
    req1 = mk(1'b1, 32'h1000_0001, MSIZE1, 4'b0000, 32'h0);
    lsign1 = 1'b1; #1;
    chk1("dual_c0_stall", stall, 1'b1);
    tick(); req0 = '0; req1 = '0; lsign1 = 1'b0; #1;
    chkreq("dual_slot0_req", dreq, mk(1'b1, 32'h1000_0003, MSIZE1, 4'b1000, 32'h5A00_0000));
    dresp.addr_ok = 1'b1; dresp.data_ok = 1'b1; dresp.data = 32'h0;
    tick(); dresp = '0; #1;
    chkreq("dual_slot1_req", dreq, mk(1'b1, 32'h1000_0001, MSIZE1, 4'b0000, 32'h0));
    dresp.addr_ok = 1'b1; dresp.data_ok = 1'b1; dresp.data = 32'h0000_8000;
    tick(); dresp = '0; #1;
    chk1("dual_done_stall", stall, 1'b0);
    chk32("dual_rdata1", rdata1, 32'hFFFF_FF80);
    chk32("dual_rdata0_store", rdata0, 32'h0);
    tick();

    // addr_ok withheld for 5 cycles on slot 0.
    r0 = mk(1'b1, 32'h2000_0020, MSIZE4, 4'h0, 32'h0);
    req0 = r0; req1 = mk(1'b1, 32'h2000_0024, MSIZE4, 4'h0, 32'h0); #1;
    for (int i = 0; i < 5; i++) begin
      tick(); req0 = rnd_req(1'b1); req1 = rnd_req(1'b1); #1;
      chkreq("hold_dreq_stable", dreq, r0);
    end
    tick(); req0 = '0; req1 = '0; #1;
    chkreq("hold_dreq_accept", dreq, r0);
    dresp.addr_ok = 1'b1;
    tick(); dresp = '0; #1;
    chk1("hold_wait_valid_a", dreq.valid, 1'b0);
    tick(); #1;
    chk1("hold_wait_valid_b", dreq.valid, 1'b0);
    dresp.data_ok = 1'b1; dresp.data = 32'h1;
    tick(); dresp = '0; #1;
    chk1("hold_slot1_valid", dreq.valid, 1'b1);
    chk32("hold_slot1_addr", dreq.addr, 32'h2000_0024);
    dresp.addr_ok = 1'b1; dresp.data_ok = 1'b1; dresp.data = 32'h2;
    tick(); dresp = '0; #1;
    chk1("hold_done_stall", stall, 1'b0);
    chk32("hold_rdata0", rdata0, 32'h1);
    chk32("hold_rdata1", rdata1, 32'h2);
    tick();

    // Flush in REQ0 without addr_ok: drop everything, slot 1 never issued.
    req0 = mk(1'b1, 32'h3000_0030, MSIZE4, 4'hF, 32'h1234);
    req1 = mk(1'b1, 32'h3000_0034, MSIZE4, 4'h0, 32'h0); #1;
    tick(); req0 = '0; req1 = '0; #1;
    cp0_flush = 1'b1; #1;
    chk1("flreq_drop_valid", dreq.valid, 1'b0);
    tick(); cp0_flush = 1'b0; #1;
    chk1("flreq_idle_stall", stall, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk1("flreq_no_slot1", dreq.valid, 1'b0);
      tick(); #1;
    end

    // Flush in IDLE: the offered group is not taken.
    req0 = mk(1'b1, 32'h3000_0040, MSIZE4, 4'h0, 32'h0); cp0_flush = 1'b1;
    tick(); req0 = '0; cp0_flush = 1'b0; #1;
    chk1("flidle_valid", dreq.valid, 1'b0);
    chk1("flidle_stall", stall, 1'b0);

    // Flush in WAIT1: drain the accepted slot-1 access, discard its data.
    tick();
    req0 = mk(1'b1, 32'h4000_0040, MSIZE4, 4'h0, 32'h0);
    req1 = mk(1'b1, 32'h4000_0044, MSIZE4, 4'h0, 32'h0); #1;
    tick(); req0 = '0; req1 = '0; #1;
    chk32("flw1_slot0_addr", dreq.addr, 32'h4000_0040);
    dresp.addr_ok = 1'b1; dresp.data_ok = 1'b1; dresp.data = 32'h1122_3344;
    tick(); dresp = '0; #1;
    chk32("flw1_slot1_addr", dreq.addr, 32'h4000_0044);
    dresp.addr_ok = 1'b1;
    tick(); dresp = '0; cp0_flush = 1'b1; #1;
    chk1("flw1_wait_stall", stall, 1'b1);
    tick(); #1;
    chk1("flw1_drain_stall", stall, 1'b1);
    chk1("flw1_drain_valid", dreq.valid, 1'b0);
    tick(); cp0_flush = 1'b0; #1;
    chk1("flw1_drain_stall2", stall, 1'b1);
    dresp.data_ok = 1'b1; dresp.data = 32'hCAFE_F00D;
    tick(); dresp = '0; #1;
    chk1("flw1_idle_stall", stall, 1'b0);
    chk32("flw1_rdata0", rdata0, 32'h0);
    chk32("flw1_rdata1", rdata1, 32'h0);

    // Reset pulsed in WAIT0.
    tick(); req0 = mk(1'b1, 32'h5000_0050, MSIZE4, 4'h0, 32'h0); #1;
    tick(); req0 = '0; #1;
    dresp.addr_ok = 1'b1;
    tick(); dresp = '0; #1;
    chk1("rst_wait_stall", stall, 1'b1);
    #2 resetn = 1'b0; #1;
    chk1("rst_async_stall", stall, 1'b0);
    chkreq("rst_async_dreq", dreq, zero_req);
    tick(); resetn = 1'b1; #1;
    chk1("rst_idle_stall", stall, 1'b0);
    tick(); #1;
    chk1("rst_idle_valid", dreq.valid, 1'b0);

    // Alignment table, each vector as a one-slot access acked in a single cycle.
    vecs[0] = '{MSIZE1, 2'd0, 1'b1, 4'h0, 32'h1234_5680, 32'hFFFF_FF80};
    vecs[1] = '{MSIZE1, 2'd2, 1'b0, 4'h0, 32'h00AB_0000, 32'h0000_00AB};
    vecs[2] = '{MSIZE1, 2'd3, 1'b1, 4'h0, 32'h7F00_0000, 32'h0000_007F};
    vecs[3] = '{MSIZE1, 2'd3, 1'b1, 4'h0, 32'hFE00_0000, 32'hFFFF_FFFE};
    vecs[4] = '{MSIZE2, 2'd0, 1'b1, 4'h0, 32'h0000_8001, 32'hFFFF_8001};
    vecs[5] = '{MSIZE2, 2'd2, 1'b0, 4'h0, 32'h9ABC_0000, 32'h0000_9ABC};
    vecs[6] = '{MSIZE2, 2'd2, 1'b1, 4'h0, 32'h9ABC_1234, 32'hFFFF_9ABC};
    vecs[7] = '{MSIZE4, 2'd0, 1'b1, 4'h0, 32'h8000_0000, 32'h8000_0000};
    vecs[8] = '{MSIZE4, 2'd0, 1'b0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
    for (int i = 0; i < 9; i++) begin
      tick();
      r0 = mk(1'b1, {30'h0400_0000, vecs[i].a}, vecs[i].sz, vecs[i].st, 32'h0);
      if (i % 2 == 1) begin req1 = r0; lsign1 = vecs[i].sg; end
      else            begin req0 = r0; lsign0 = vecs[i].sg; end
      tick(); req0 = '0; req1 = '0; #1;
      chkreq("tbl_dreq", dreq, r0);
      dresp.addr_ok = 1'b1; dresp.data_ok = 1'b1; dresp.data = vecs[i].bus;
      tick(); dresp = '0; #1;
      chk1("tbl_done_stall", stall, 1'b0);
      chk32("tbl_rdata", (i % 2 == 1) ? rdata1 : rdata0, vecs[i].exp);
      chk32("tbl_rdata_other", (i % 2 == 1) ? rdata0 : rdata1, 32'h0);
    end

    // Random groups with random bus latencies; inputs are garbage after the latch cycle.
    tick();
    for (int g = 0; g < 150; g++) begin
      r[0] = rnd_req($urandom_range(0, 3) != 0);
      r[1] = rnd_req($urandom_range(0, 3) != 0);
      if (!r[0].valid && !r[1].valid) r[0].valid = 1'b1;
      sg[0] = 1'($urandom_range(0, 1));
      sg[1] = 1'($urandom_range(0, 1));
      exp_rd[0] = '0; exp_rd[1] = '0;
      order.delete();
      for (int s = 0; s < 2; s++) if (r[s].valid) order.push_back(s);
      req0 = r[0]; req1 = r[1]; lsign0 = sg[0]; lsign1 = sg[1]; cp0_flush = 1'b0; dresp = '0; #1;
      chk1("rnd_latch_stall", stall, 1'b1);
      idx = 0; pend = 1'b0; hold = 1'b0; done = 1'b0; cnt = 0; prev = '0;
      for (int c = 0; c < 60 && !done; c++) begin
        tick();
        req0 = rnd_req(1'($urandom_range(0, 1)));
        req1 = rnd_req(1'($urandom_range(0, 1)));
        lsign0 = 1'($urandom_range(0, 1)); lsign1 = 1'($urandom_range(0, 1));
        dresp = '0; #1;
        if (!stall) begin
          chk32("rnd_done_count", 32'(idx), 32'(order.size()));
          chk32("rnd_rdata0", rdata0, exp_rd[0]);
          chk32("rnd_rdata1", rdata1, exp_rd[1]);
          done = 1'b1;
        end else if (pend) begin
          chk1("rnd_wait_valid", dreq.valid, 1'b0);
          if (cnt == 1) begin
            bd = $urandom;
            dresp.data_ok = 1'b1; dresp.data = bd;
            slot = order[idx];
            exp_rd[slot] = (r[slot].strobe == 4'h0) ? ref_align(bd, r[slot].addr[1:0], r[slot].size, sg[slot]) : 32'h0;
            idx++; pend = 1'b0;
          end else cnt--;
        end else if (dreq.valid) begin
          if (idx >= order.size()) begin
            chk1("rnd_extra_req", dreq.valid, 1'b0);
          end else begin
            slot = order[idx];
            chkreq("rnd_dreq", dreq, r[slot]);
            if (hold) chkreq("rnd_dreq_stable", dreq, prev);
            if ($urandom_range(0, 2) == 0) begin
              hold = 1'b1; prev = dreq;
            end else begin
              hold = 1'b0;
              dresp.addr_ok = 1'b1;
              nd = $urandom_range(0, 2);
              if (nd == 0) begin
                bd = $urandom;
                dresp.data_ok = 1'b1; dresp.data = bd;
                exp_rd[slot] = (r[slot].strobe == 4'h0) ? ref_align(bd, r[slot].addr[1:0], r[slot].size, sg[slot]) : 32'h0;
                idx++;
              end else begin
                pend = 1'b1; cnt = nd;
              end
            end
          end
        end
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL rnd_timeout: group %0d got no DONE within 60 cycles, expected DONE", g);
      end
      tick();
      req0 = '0; req1 = '0; dresp = '0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Sits between the two memory-issue slots (AGU outputs, slot 0 older) and the single data-bus port.
- Serialises both slots' dbus requests in program order and holds each request stable until the bus accepts it.
- Collects load data, aligns and extends it, and stalls the pipeline until every request in the issue group completes.
- Handles CP0 flush: requests not yet sent are dropped; requests already accepted are drained.

Parameters:
- none (slot count fixed at 2; slot 0 always precedes slot 1)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req0  in  dbus_req_t  slot-0 request from AGU (valid, addr, size, strobe, data)
- req1  in  dbus_req_t  slot-1 request from AGU
- lsign0  in  1  slot-0 load sign-extends (LB/LH=1, LBU/LHU=0; ignored for stores and for size MSIZE4)
- lsign1  in  1  slot-1 load sign-extends
- cp0_flush  in  1  exception/eret flush
- dreq  out  dbus_req_t  to data bus
- dresp  in  dbus_resp_t  from data bus (addr_ok, data_ok, data)
- stall  out  1  freeze issue group while high
- rdata0  out  32  slot-0 aligned load result, valid while state==DONE
- rdata1  out  32  slot-1 aligned load result, valid while state==DONE

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; all latched requests, result registers and dreq cleared to '0.
  - stall=0; rdata0=rdata1=0.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DRAIN, DONE.
- IDLE:
  - If cp0_flush=1, take nothing and stay in IDLE.
  - Otherwise, if req0.valid|req1.valid, latch both requests and lsign bits.
  - Next state is REQ0 if req0.valid, else REQ1.
  - stall is combinationally 1 in that same cycle.
- REQx:
  - dreq = latched reqx with valid=1; dreq is held bit-stable until addr_ok.
  - addr_ok & data_ok in the same cycle: capture data, advance (see "Advance").
  - addr_ok only: go to WAITx.
- WAITx:
  - dreq.valid=0.
  - On data_ok, capture dresp.data into slot register and advance.
- Advance:
  - From slot 0: go to REQ1 if latched req1.valid, else DONE.
  - From slot 1: go to DONE.
- DONE:
  - stall=0 for exactly one cycle; rdata0/rdata1 hold aligned results (0 for stores or invalid slots).
  - Inputs are ignored in this cycle. Next state: IDLE.
- stall=1 in every state except IDLE-with-no-valid-request and DONE.
- Flush, in any REQx/WAITx:
  - REQx with addr_ok=0 in the flush cycle: dreq.valid drops that cycle; go to IDLE.
  - REQx with addr_ok=1 in the flush cycle: go to DRAIN, or to IDLE if data_ok is also 1 that cycle.
  - WAITx: go to DRAIN, or to IDLE if data_ok=1 that cycle.
  - The pending slot-1 request is never issued after a flush.
- DRAIN:
  - dreq.valid=0, stall=1; wait for data_ok, discard the data, go to IDLE.
  - cp0_flush has no further effect here.
- Load alignment, by size and addr[1:0]:
  - MSIZE1: byte = data[8*a+7:8*a].
  - MSIZE2: half = data[16*a[1]+15:16*a[1]].
  - MSIZE4: full word.
  - Zero- or sign-extend to 32 per lsign.
  - Misaligned requests never arrive, because the AGU clears valid on AdEL/AdES.
- A stores-only group still waits for data_ok on each store.
- Reset asserted mid-transaction returns to IDLE immediately. The bus side is reset by the same resetn, so no drain is needed.

Decomposition:
- Shared package (common.svh / instr.svh): dbus_req_t, dbus_resp_t, msize_t (MSIZE1/2/4), strobe_t, word_t, addr_t.
- Local to this block: the arbiter state enum.
- Sub-module load_align (combinational): inputs data, addr[1:0], size, lsign; output word_t.
  - Instantiated twice, on the captured registers.

Test Plan:
- Single LW in slot 0, addr=0x8000_0010:
  - Stimulus: addr_ok in cycle 1, data_ok with 0xDEADBEEF in cycle 3.
  - Response: dreq.valid high for 1 cycle, stall=1 for 4 cycles, then DONE with rdata0=0xDEADBEEF, stall=0.
- Dual issue, SB slot0 (addr 0x..03, data 0x5A) + LB slot1 (addr 0x..01, lsign=1):
  - Stimulus: bus returns addr_ok&data_ok same cycle; load data=0x0000_8000.
  - Response: slot0 dreq has strobe=4'b1000 and precedes slot1; rdata1=0xFFFF_FF80.
- addr_ok held low 5 cycles on slot 0:
  - Response: dreq bit-identical all 5 cycles; slot 1 not issued until slot-0 data_ok.
- cp0_flush in REQ0 with addr_ok=0:
  - Response: next cycle state IDLE, dreq.valid=0, slot 1 never appears on the bus, no DONE cycle.
- cp0_flush in WAIT1:
  - Response: enter DRAIN with stall=1; data_ok 2 cycles later is discarded; return to IDLE with rdata unchanged (0).
- resetn pulsed low in WAIT0:
  - Response: stall=0, dreq=0 asynchronously; state IDLE after release.
